mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore-style FSM that sequences a multicycle MIPS datapath built from the existing blocks: PC register, single shared instruction/data memory, register file, ALU and ALU control.
- Every instruction is split into 3-5 states. Per cycle, the FSM drives all mux selects and write enables.
- A mem_ready handshake stretches the memory states to cover slow memory.
- A retired-instruction counter is provided for debug and bench checking.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states hold until mem_ready=1; 0 = mem_ready is ignored and treated as 1.
- CNT_WIDTH, 32: width of retired_count.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCondEQ  out  1  load PC if ALU Zero=1
- PCWriteCondNE  out  1  load PC if ALU Zero=0
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  2  write register select: 00=rt, 01=rd, 10=$31
- MemtoReg  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0=PC, 1=regA
- ALUSrcB  out  2  ALU B select: 00=regB, 01=4, 10=sext(imm), 11=sext(imm)<<2
- ALUOp  out  3  000=add, 001=sub, 010=R-type (use funct), 011=and, 100=or, 101=lui
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=regA (jr)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_out  out  4  current state encoding
- retired_count  out  CNT_WIDTH  count of completed instructions

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, JR=13
  - Codes 14 and 15 are unreachable; if entered, go to FETCH.
- Outputs are decoded from the state register only, with one exception: IRWrite and PCWrite in FETCH are gated by mem_ready. Every output not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, IRWrite=PCWrite=mem_ready. Go to DECODE when ready, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (computes branch target into ALUOut). Next state by opcode:
  - lw 100011 / sw 101011 -> MEM_ADDR
  - 000000 -> JR if funct=001000, else R_EXEC
  - beq 000100 / bne 000101 -> BRANCH
  - addi 001000 / andi 001100 / ori 001101 / lui 001111 -> I_EXEC
  - j 000010 -> JUMP
  - jal 000011 -> JAL
  - any other opcode -> FETCH, with illegal_op=1 in this cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, MemRead=1. Go to MEM_WB when ready, else hold.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1. Next: FETCH.
- MEM_WRITE: IorD=1, MemWrite=1, held asserted until ready. Then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next: R_WB.
- R_WB: RegDst=01, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWriteCondEQ=1 for beq, PCWriteCondNE=1 for bne. Next: FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp by opcode: addi=000, andi=011, ori=100, lui=101. Next: I_WB.
- I_WB: RegDst=00, RegWrite=1. Next: FETCH.
- JUMP: PCSource=10, PCWrite=1. Next: FETCH.
- JAL: PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1. Next: FETCH. The register file captures the pre-edge PC, which already holds PC+4.
- JR: PCSource=11, PCWrite=1. Next: FETCH.
- Latency in cycles, with MEM_WAIT_EN=0 or mem_ready constantly 1:
  - lw=5; sw=4; R-type=4; I-type=4
  - beq/bne=3; j/jr=3; jal=3
  - illegal=2
  - Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1.
- opcode and funct are sampled only in DECODE. Downstream states re-use opcode; IR is stable because IRWrite=0 outside FETCH.
- retired_count increments by 1 on every edge where the state leaves a terminal state (MEM_WB, MEM_WRITE, R_WB, BRANCH, I_WB, JUMP, JAL, JR) for FETCH. It is not incremented on illegal opcodes. It wraps modulo 2^CNT_WIDTH.
- Reset:
  - On a clock edge with reset=1: state=FETCH, retired_count=0.
  - While reset=1, PCWrite, PCWriteCondEQ/NE, IRWrite, RegWrite, MemWrite and illegal_op are forced to 0 combinationally. Reset mid-instruction therefore never produces a partial write.
  - After reset releases, outputs are the FETCH values: MemRead=1, ALUSrcB=01, rest 0, and IRWrite/PCWrite follow mem_ready.

Test Plan:
- Reset, then lw (opcode 100011) with mem_ready=1 -> state_out 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=01; retired_count=1.
- sw with mem_ready held 0 for 3 cycles in MEM_WRITE -> MemWrite=1 for exactly 4 cycles; no FETCH until ready; total 7 cycles.
- beq then bne -> PCWriteCondEQ=1 only in BRANCH for beq; PCWriteCondNE=1 only for bne; PCSource=01; 3 cycles each.
- jal -> JAL state asserts PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10; R-type funct 001000 -> JR state with PCSource=11.
- opcode 111111 -> illegal_op pulses once in DECODE; returns to FETCH; retired_count unchanged.
- reset asserted during MEM_WRITE with mem_ready=0 -> MemWrite=0 in the same cycle; state_out=0 after the edge; retired_count=0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_multicycle_control: Moore FSM sequencing a multicycle MIPS   |
// | datapath with a mem_ready stretch.      Rev 1.0                   |
// +------------------------------------------------------------------+
module mips_multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCondEQ,
  output logic                 PCWriteCondNE,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 illegal_op,
  output logic [3:0]           state_out,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
    S_JAL = 4'd12, S_JR = 4'd13
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       condeq;
    logic       condne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_JAL  = 6'b000011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [5:0] c_OP_ANDI = 6'b001100;
  localparam logic [5:0] c_OP_ORI  = 6'b001101;
  localparam logic [5:0] c_OP_LUI  = 6'b001111;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_FN_JR   = 6'b001000;
  localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;
  ctrl_t                  r_ctrl;
  logic [CNT_WIDTH-1:0]   r_retired;
  logic                   w_ready;
  logic                   w_legal;
  logic                   w_terminal;
  logic                   w_retire;

  // Control word for a state; opcode is stable from DECODE onward.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.memread = 1'b1; c.alusrcb = 2'b01;
                         c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:    c.alusrcb = 2'b11;
      S_MEM_ADDR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEM_READ:  begin c.iord = 1'b1; c.memread = 1'b1; end
      S_MEM_WB:    begin c.memtoreg = 2'b01; c.regwrite = 1'b1; end
      S_MEM_WRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_R_EXEC:    begin c.alusrca = 1'b1; c.aluop = 3'b010; end
      S_R_WB:      begin c.regdst = 2'b01; c.regwrite = 1'b1; end
      S_BRANCH:    begin c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsource = 2'b01;
                         c.condeq = (op == c_OP_BEQ); c.condne = (op == c_OP_BNE); end
      S_JUMP:      begin c.pcsource = 2'b10; c.pcwrite = 1'b1; end
      S_I_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        case (op)
          c_OP_ANDI: c.aluop = 3'b011;
          c_OP_ORI:  c.aluop = 3'b100;
          c_OP_LUI:  c.aluop = 3'b101;
          default:   c.aluop = 3'b000;
        endcase
      end
      S_I_WB:      c.regwrite = 1'b1;
      S_JAL:       begin c.pcsource = 2'b10; c.pcwrite = 1'b1; c.regdst = 2'b10;
                         c.memtoreg = 2'b10; c.regwrite = 1'b1; end
      S_JR:        begin c.pcsource = 2'b11; c.pcwrite = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    w_next  = S_FETCH;
    w_legal = 1'b1;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW:                      w_next = S_MEM_ADDR;
          c_OP_R:    w_next = (funct == c_FN_JR) ? S_JR : S_R_EXEC;
          c_OP_BEQ, c_OP_BNE:                    w_next = S_BRANCH;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: w_next = S_I_EXEC;
          c_OP_J:                                w_next = S_JUMP;
          c_OP_JAL:                              w_next = S_JAL;
          default: begin w_next = S_FETCH; w_legal = 1'b0; end
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = w_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = w_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_I_EXEC:    w_next = S_I_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_terminal = 1'b0;
    case (r_state)
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH,
      S_I_WB, S_JUMP, S_JAL, S_JR: w_terminal = 1'b1;
      default:                     w_terminal = 1'b0;
    endcase
  end

  assign w_retire = w_terminal && (w_next == S_FETCH);

  // Outputs are registered from the next-state decode so they match the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode(S_FETCH, opcode);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next, opcode);
      if (w_retire) r_retired <= r_retired + c_ONE;
    end
  end

  assign PCWrite       = !reset && r_ctrl.pcwrite && ((r_state != S_FETCH) || w_ready);
  assign IRWrite       = !reset && r_ctrl.irwrite && w_ready;
  assign PCWriteCondEQ = !reset && r_ctrl.condeq;
  assign PCWriteCondNE = !reset && r_ctrl.condne;
  assign RegWrite      = !reset && r_ctrl.regwrite;
  assign MemWrite      = !reset && r_ctrl.memwrite;
  assign illegal_op    = !reset && (r_state == S_DECODE) && !w_legal;
  assign IorD          = r_ctrl.iord;
  assign MemRead       = r_ctrl.memread;
  assign RegDst        = r_ctrl.regdst;
  assign MemtoReg      = r_ctrl.memtoreg;
  assign ALUSrcA       = r_ctrl.alusrca;
  assign ALUSrcB       = r_ctrl.alusrcb;
  assign ALUOp         = r_ctrl.aluop;
  assign PCSource      = r_ctrl.pcsource;
  assign state_out     = r_state;
  assign retired_count = r_retired;

endmodule
`default_nettype wire
